reset_seq_gen: RTL and testbench

Multi-channel, parametrised reset sequencer that generates staggered, delayed active-low reset pulses for downstream SSD controller sub-blocks (PHY, NAND interface, host link, ...). A sequence runs automatically after power-on reset and is re-launched by a trigger code on the debug command byte; a second code aborts a running sequence. Sits between the board-level reset/debug command path and the per-domain reset inputs, and reports busy/done status.

---
 rtl/reset_seq_gen.sv | 118 +++++++++++
 tb/tb_reset_seq_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// reset_seq_gen: multi-channel staggered reset sequencer.
// Ports: clk, reset (async, active-high), cmd/cmd_valid (debug command),
//        rst_out_n[NUM_CH] (active-low resets), busy, done.
module reset_seq_gen #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          CMD_W        = 8,
    parameter int unsigned TRIG_CODE    = 55,
    parameter int unsigned ABORT_CODE   = 170,
    parameter int unsigned SEQ_LEN      = 500000000,
    parameter int unsigned ASSERT_START = 350000000,
    parameter int unsigned ASSERT_END   = 400000000,
    parameter int unsigned STAGGER      = 0,
    parameter bit          POR_AUTO     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_valid,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = POR_AUTO ? RUN : IDLE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SEQ_LEN);
    localparam logic [CMD_W-1:0] TRIG = CMD_W'(TRIG_CODE);
    localparam logic [CMD_W-1:0] ABRT = CMD_W'(ABORT_CODE);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("reset_seq_gen: NUM_CH out of range");
    end
    if (64'(ASSERT_END) <= 64'(ASSERT_START) + 64'd1) begin : g_bad_win
        $error("reset_seq_gen: assert window empty");
    end
    if (64'(SEQ_LEN) >= (64'd1 << CNT_W)) begin : g_bad_len
        $error("reset_seq_gen: SEQ_LEN does not fit counter");
    end

    logic [NUM_CH-1:0] in_win;
    logic [CNT_W-1:0]  cnt;

    // Per-channel window bounds, exclusive on both ends.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_win
        localparam logic [CNT_W-1:0] WS =
            CNT_W'(64'(ASSERT_START) + 64'(i) * 64'(STAGGER));
        localparam logic [CNT_W-1:0] WE =
            CNT_W'(64'(ASSERT_END) + 64'(i) * 64'(STAGGER));
        if (64'(ASSERT_END) + 64'(i) * 64'(STAGGER) > 64'(SEQ_LEN))
        begin : g_bad_end
            $error("reset_seq_gen: window end beyond SEQ_LEN");
        end
        assign in_win[i] = (cnt > WS) && (cnt < WE);
    end

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [NUM_CH-1:0] rst_nxt;
    logic              done_nxt;
    logic              trig, abort;

    assign trig  = cmd_valid && (cmd == TRIG);
    assign abort = cmd_valid && (cmd == ABRT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_STATE;
            cnt       <= '0;
            rst_out_n <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rst_out_n <= rst_nxt;
            busy      <= (state_nxt == RUN);
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done;
        // Outputs follow the counter value held before this edge.
        rst_nxt   = ~(in_win & {NUM_CH{state == RUN}});
        unique case (state)
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Commands override; cnt=0 lies outside every window.
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            rst_nxt   = '1;
        end else if (trig) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            rst_nxt   = '1;
        end
    end

endmodule

// File: tb/tb_reset_seq_gen.sv
// tb_reset_seq_gen: directed checks of reset_seq_gen in auto-start and
// trigger-start configurations (3 channels, SEQ_LEN=40, window 5..10, +8).
module tb_reset_seq_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, b_reset;
    logic [7:0] a_cmd, b_cmd;
    logic       a_vld, b_vld;
    logic [2:0] a_rst, b_rst;
    logic       a_busy, a_done, b_busy, b_done;

    int total = 0;
    int bad   = 0;

    reset_seq_gen #(
        .NUM_CH(3), .CNT_W(32), .CMD_W(8), .TRIG_CODE(55),
        .ABORT_CODE(170), .SEQ_LEN(40), .ASSERT_START(5),
        .ASSERT_END(10), .STAGGER(8), .POR_AUTO(1'b1)
    ) u_auto (
        .clk(clk), .reset(a_reset), .cmd(a_cmd), .cmd_valid(a_vld),
        .rst_out_n(a_rst), .busy(a_busy), .done(a_done)
    );

    reset_seq_gen #(
        .NUM_CH(3), .CNT_W(32), .CMD_W(8), .TRIG_CODE(55),
        .ABORT_CODE(170), .SEQ_LEN(40), .ASSERT_START(5),
        .ASSERT_END(10), .STAGGER(8), .POR_AUTO(1'b0)
    ) u_idle (
        .clk(clk), .reset(b_reset), .cmd(b_cmd), .cmd_valid(b_vld),
        .rst_out_n(b_rst), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge k after start: channel i low for edges 7+8i .. 10+8i.
    function automatic logic [2:0] exp_rst(input int k);
        logic [2:0] r;
        r = 3'b111;
        for (int i = 0; i < 3; i++)
            if (k >= 7 + 8 * i && k <= 10 + 8 * i) r[i] = 1'b0;
        return r;
    endfunction

    task automatic run_check(input bit use_b, input string tag);
        for (int k = 1; k <= 45; k++) begin
            tick();
            chk($sformatf("%s rst k=%0d", tag, k),
                use_b ? b_rst : a_rst, exp_rst(k));
            chk($sformatf("%s busy k=%0d", tag, k),
                use_b ? b_busy : a_busy, k <= 40);
            chk($sformatf("%s done k=%0d", tag, k),
                use_b ? b_done : a_done, k > 40);
        end
    endtask

    task automatic trig_a();
        a_cmd = 8'd55;
        a_vld = 1'b1;
        tick();
        a_vld = 1'b0;
        a_cmd = 8'd0;
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_cmd = 8'd0;   b_cmd = 8'd0;
        a_vld = 1'b0;   b_vld = 1'b0;
        repeat (3) tick();
        chk("a rst in reset", a_rst, 3'b111);
        chk("a busy in reset", a_busy, 1'b0);
        chk("a done in reset", a_done, 1'b0);
        chk("b rst in reset", b_rst, 3'b111);
        chk("b busy in reset", b_busy, 1'b0);

        // Power-on auto run.
        a_reset = 1'b0;
        run_check(1'b0, "por");

        // Trigger-started configuration.
        b_reset = 1'b0;
        repeat (100) tick();
        chk("idle rst", b_rst, 3'b111);
        chk("idle busy", b_busy, 1'b0);
        chk("idle done", b_done, 1'b0);
        b_cmd = 8'd55;
        b_vld = 1'b1;
        tick();
        b_vld = 1'b0;
        chk("b trig busy", b_busy, 1'b1);
        chk("b trig rst", b_rst, 3'b111);
        run_check(1'b1, "trig");

        // Retrigger while channel 1 is low.
        trig_a();
        chk("retrig0 done", a_done, 1'b0);
        chk("retrig0 busy", a_busy, 1'b1);
        repeat (16) tick();
        chk("ch1 low", a_rst, 3'b101);
        trig_a();
        chk("retrig rst", a_rst, 3'b111);
        chk("retrig busy", a_busy, 1'b1);
        chk("retrig done", a_done, 1'b0);
        run_check(1'b0, "retrig");

        // Held trigger.
        a_cmd = 8'd55;
        a_vld = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("held rst %0d", k), a_rst, 3'b111);
            chk($sformatf("held busy %0d", k), a_busy, 1'b1);
        end
        a_vld = 1'b0;
        run_check(1'b0, "held");

        // Abort mid-window, then ignored commands.
        trig_a();
        repeat (8) tick();
        chk("pre abort", a_rst, 3'b110);
        a_cmd = 8'd170;
        a_vld = 1'b1;
        tick();
        a_vld = 1'b0;
        chk("abort rst", a_rst, 3'b111);
        chk("abort busy", a_busy, 1'b0);
        chk("abort done", a_done, 1'b0);
        a_cmd = 8'd55;
        repeat (10) tick();
        chk("novld busy", a_busy, 1'b0);
        chk("novld rst", a_rst, 3'b111);
        a_cmd = 8'h12;
        a_vld = 1'b1;
        repeat (5) tick();
        a_vld = 1'b0;
        chk("other cmd busy", a_busy, 1'b0);
        chk("other cmd done", a_done, 1'b0);
        trig_a();
        run_check(1'b0, "post_abort");

        // Asynchronous reset mid-window.
        trig_a();
        repeat (8) tick();
        chk("pre areset", a_rst, 3'b110);
        #2 a_reset = 1'b1;
        #1;
        chk("areset rst", a_rst, 3'b111);
        chk("areset busy", a_busy, 1'b0);
        chk("areset done", a_done, 1'b0);
        repeat (2) tick();
        a_reset = 1'b0;
        run_check(1'b0, "por2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
